// File: rtl/kbd_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the PS/2 keyboard scan-code decoder:
//   KEYCODE_WIDTH  - default width of the decoded key code {ext, scan byte}
//   PREFIX_EXT     - 0xE0, marks the next code as an extended key
//   PREFIX_BRK     - 0xF0, marks the next code as a key release
//   PREFIX_PAUSE   - 0xE1, Pause/Break prefix, swallowed without effect
//   frame_state_t  - states of the 11-bit PS/2 frame receiver
// ---------------------------------------------------------------------------
package kbd_pkg;

    localparam int KEYCODE_WIDTH = 9;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] PREFIX_PAUSE = 8'hE1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Receives one 11-bit PS/2 frame (start, 8 data LSB first, parity, stop) from
// the raw keyboard lines and emits the data byte as a one-cycle strobe.
//
// Ports:
//   clk, resetN  - system clock, asynchronous active-low reset
//   kbd_clk      - raw PS/2 clock line (asynchronous)
//   kbd_dat      - raw PS/2 data line (asynchronous)
//   rx_byte      - last accepted data byte
//   byte_valid   - one-cycle strobe, rx_byte holds a freshly accepted byte
//   frame_abort  - one-cycle strobe, a frame was dropped by the watchdog or
//                  (when parity checking is built in) failed odd parity
//
// Build option: define KBD_PARITY_CHECK_EN to reject frames with bad odd
// parity; otherwise the parity bit is consumed and ignored.
// ---------------------------------------------------------------------------
module ps2_frame_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       kbd_clk,
    input  logic       kbd_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_abort
);

    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic                clk_s1;
    logic                clk_s2;
    logic                clk_prev;
    logic                dat_s1;
    logic                dat_s2;
    logic                kbd_fall;
    frame_state_t        state;
    frame_state_t        next_state;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift_reg;
    logic [WD_WIDTH-1:0] wd_cnt;
    logic                timeout;
    logic                parity_ok;

    // Two-flop synchronizers for both PS/2 lines, plus one extra stage on the
    // clock so a falling edge can be seen. Everything resets to 1 because an
    // idle PS/2 bus is pulled high, which keeps reset release from looking
    // like a falling edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= kbd_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= kbd_dat;
            dat_s2   <= dat_s1;
        end
    end

    assign kbd_fall = clk_prev & ~clk_s2;
    assign timeout  = (state != IDLE) && (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES));

    // Watchdog: counts cycles since the last keyboard clock edge while a frame
    // is open. Held at zero in IDLE so it cannot expire between frames.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wd_cnt <= '0;
        end else if (kbd_fall || state == IDLE) begin
            wd_cnt <= '0;
        end else if (!timeout) begin
            wd_cnt <= wd_cnt + WD_WIDTH'(1);
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A watchdog expiry beats any edge arriving in the same
    // cycle, so a stale frame is always abandoned. A 1 seen in IDLE is line
    // noise, not a start bit, and is ignored.
    always_comb begin
        next_state = state;
        if (timeout) begin
            next_state = IDLE;
        end else if (kbd_fall) begin
            case (state)
                IDLE:    if (!dat_s2) next_state = DATA;
                DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY:  next_state = STOP;
                STOP:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Data shifter: bits arrive LSB first, so each new bit enters at the top
    // and the first bit ends up in bit 0 after eight shifts.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (kbd_fall && !timeout) begin
            case (state)
                IDLE: bit_cnt <= '0;
                DATA: begin
                    shift_reg <= {dat_s2, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef KBD_PARITY_CHECK_EN
    logic parity_bit;

    // Capture the parity bit so the stop-bit cycle can judge the whole byte.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            parity_bit <= 1'b0;
        end else if (kbd_fall && !timeout && state == PARITY) begin
            parity_bit <= dat_s2;
        end
    end

    // Odd parity: data plus parity must carry an odd number of ones.
    assign parity_ok = ^{shift_reg, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    // Result strobes, decided on the stop-bit edge. A bad parity is reported
    // as an abort so the prefix state upstream is flushed; a bad stop bit
    // just drops the byte quietly.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rx_byte     <= '0;
            byte_valid  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_abort <= 1'b0;
            if (timeout) begin
                frame_abort <= 1'b1;
            end else if (kbd_fall && state == STOP) begin
                if (!parity_ok) begin
                    frame_abort <= 1'b1;
                end else if (dat_s2) begin
                    rx_byte    <= shift_reg;
                    byte_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/kbd_scan_decoder.sv
// ---------------------------------------------------------------------------
// kbd_scan_decoder
// PS/2 keyboard scan-code decoder. Turns the raw keyboard lines into key
// codes with make (press) and brake (release) pulses, folding in the E0
// extended and F0 release prefixes.
//
// Ports:
//   clk, resetN - system clock, asynchronous active-low reset
//   kbd_clk     - raw PS/2 clock line (asynchronous)
//   kbd_dat     - raw PS/2 data line (asynchronous)
//   keyCode     - last decoded key, {E0 extended flag, scan byte}
//   make        - one-cycle pulse, key pressed
//   brake       - one-cycle pulse, key released
//
// Build option: define KBD_PARITY_CHECK_EN to enable odd-parity checking in
// the frame receiver.
// ---------------------------------------------------------------------------
module kbd_scan_decoder #(
    parameter int KEYCODE_WIDTH  = kbd_pkg::KEYCODE_WIDTH,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     kbd_clk,
    input  logic                     kbd_dat,
    output logic [KEYCODE_WIDTH-1:0] keyCode,
    output logic                     make,
    output logic                     brake
);

    import kbd_pkg::*;

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_abort;
    logic       ext_flag;
    logic       brk_flag;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk        (clk),
        .resetN     (resetN),
        .kbd_clk    (kbd_clk),
        .kbd_dat    (kbd_dat),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_abort(frame_abort)
    );

    // Prefix tracking and output registers. Prefix bytes only set flags and
    // never reach keyCode; E1 (Pause) is swallowed and leaves the flags alone.
    // Any other byte completes a key event: keyCode is loaded in the same
    // cycle the pulse rises, and the flags are spent. A dropped frame flushes
    // the flags so a half-seen sequence cannot taint the next key.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            keyCode  <= '0;
            make     <= 1'b0;
            brake    <= 1'b0;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else begin
            make  <= 1'b0;
            brake <= 1'b0;
            if (frame_abort) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_valid) begin
                case (rx_byte)
                    PREFIX_EXT:   ext_flag <= 1'b1;
                    PREFIX_BRK:   brk_flag <= 1'b1;
                    PREFIX_PAUSE: ;
                    default: begin
                        keyCode  <= KEYCODE_WIDTH'({ext_flag, rx_byte});
                        make     <= ~brk_flag;
                        brake    <= brk_flag;
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kbd_scan_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_kbd_scan_decoder
// Self-checking bench for kbd_scan_decoder. Key events expected from each
// frame are queued when the frame is driven and matched against make/brake
// pulses as they appear, including pulse latency from the stop-bit edge.
// ---------------------------------------------------------------------------
module tb_kbd_scan_decoder;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 6;
    localparam int NVEC    = 17;

    logic       clk = 1'b0;
    logic       resetN;
    logic       kbd_clk;
    logic       kbd_dat;
    logic [8:0] keyCode;
    logic       make;
    logic       brake;

    typedef struct {
        logic [8:0] code;
        logic       mk;
        logic       br;
    } expect_t;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic       pulse;
        logic [8:0] code;
        logic       mk;
        logic       br;
    } vector_t;

    expect_t    sb[$];
    expect_t    mon_e;
    expect_t    push_e;
    vector_t    vec [0:NVEC-1];
    int         num_checks = 0;
    int         num_errors = 0;
    int         cycle_cnt  = 0;
    int         stop_cycle = 0;
    logic [8:0] last_code;
    logic       found;

    always #5 clk = ~clk;

    kbd_scan_decoder #(
        .KEYCODE_WIDTH (9),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .kbd_clk(kbd_clk),
        .kbd_dat(kbd_dat),
        .keyCode(keyCode),
        .make   (make),
        .brake  (brake)
    );

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives the first nbits bits of a PS/2 frame: start, data LSB first,
    // odd parity (optionally corrupted), stop (optionally forced to 0).
    task automatic applyStimulus(input logic [7:0] data, input logic bad_par,
                                 input logic bad_stop, input int nbits);
        logic [10:0] frame;
        frame = {~bad_stop, (~(^data)) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            kbd_dat = frame[i];
            repeat (HALF) @(negedge clk);
            kbd_clk = 1'b0;
            if (i == 10) stop_cycle = cycle_cnt;
            repeat (HALF) @(negedge clk);
            kbd_clk = 1'b1;
        end
    endtask

    task automatic expectKey(input logic [8:0] code, input logic mk, input logic br);
        push_e.code = code;
        push_e.mk   = mk;
        push_e.br   = br;
        sb.push_back(push_e);
        last_code = code;
    endtask

    // Scoreboard monitor: every pulse must match the oldest queued event and
    // appear four system clocks after the stop-bit edge is driven (two sync
    // stages, then two cycles after the edge is detected).
    always @(negedge clk) begin
        if (resetN && (make || brake)) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {30'b0, make, brake}, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("pulse_keycode", 32'(keyCode), 32'(mon_e.code));
                checkOutput("pulse_make", 32'(make), 32'(mon_e.mk));
                checkOutput("pulse_brake", 32'(brake), 32'(mon_e.br));
                checkOutput("pulse_latency", cycle_cnt - stop_cycle, 32'd4);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vec[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 9'h01C, 1'b1, 1'b0};
        vec[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vec[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vec[3]  = '{8'h4A, 1'b0, 1'b0, 1'b1, 9'h14A, 1'b0, 1'b1};
        vec[4]  = '{8'h4A, 1'b0, 1'b0, 1'b1, 9'h04A, 1'b1, 1'b0};
        vec[5]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vec[6]  = '{8'h75, 1'b0, 1'b0, 1'b1, 9'h075, 1'b0, 1'b1};
        vec[7]  = '{8'h6C, 1'b0, 1'b0, 1'b1, 9'h06C, 1'b1, 1'b0};
        vec[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vec[9]  = '{8'hE1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vec[10] = '{8'h70, 1'b0, 1'b0, 1'b1, 9'h170, 1'b1, 1'b0};
        vec[11] = '{8'hE0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
`ifdef KBD_PARITY_CHECK_EN
        vec[12] = '{8'h1C, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
`else
        vec[12] = '{8'h1C, 1'b1, 1'b0, 1'b1, 9'h11C, 1'b1, 1'b0};
`endif
        vec[13] = '{8'h1C, 1'b0, 1'b0, 1'b1, 9'h01C, 1'b1, 1'b0};
        vec[14] = '{8'hE0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vec[15] = '{8'h33, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
        vec[16] = '{8'h33, 1'b0, 1'b0, 1'b1, 9'h133, 1'b1, 1'b0};

        // Reset state
        resetN  = 1'b0;
        kbd_clk = 1'b1;
        kbd_dat = 1'b1;
        last_code = 9'h000;
        repeat (3) @(negedge clk);
        checkOutput("reset_keycode", 32'(keyCode), 32'h0);
        checkOutput("reset_make", 32'(make), 32'h0);
        checkOutput("reset_brake", 32'(brake), 32'h0);
        resetN = 1'b1;
        repeat (5) @(negedge clk);

        // Table of back-to-back frames
        for (int i = 0; i < NVEC; i++) begin
            if (vec[i].pulse) expectKey(vec[i].code, vec[i].mk, vec[i].br);
            applyStimulus(vec[i].data, vec[i].bad_par, vec[i].bad_stop, 11);
            checkOutput($sformatf("vec%0d_keycode", i), 32'(keyCode), 32'(last_code));
        end

        // Watchdog: E0, then a frame stalled after 4 data bits; the abort must
        // also drop the pending extended flag.
        repeat (20) @(negedge clk);
        applyStimulus(8'hE0, 1'b0, 1'b0, 11);
        applyStimulus(8'h33, 1'b0, 1'b0, 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        checkOutput("stall_keycode", 32'(keyCode), 32'(last_code));
        expectKey(9'h05A, 1'b1, 1'b0);
        applyStimulus(8'h5A, 1'b0, 1'b0, 11);
        checkOutput("after_stall_keycode", 32'(keyCode), 32'(last_code));

        // Reset in the middle of a frame after an E0 prefix
        applyStimulus(8'hE0, 1'b0, 1'b0, 11);
        applyStimulus(8'h77, 1'b0, 1'b0, 6);
        @(negedge clk);
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_keycode", 32'(keyCode), 32'h0);
        checkOutput("midreset_make", 32'(make), 32'h0);
        resetN = 1'b1;
        last_code = 9'h000;
        repeat (3) @(negedge clk);
        expectKey(9'h06B, 1'b1, 1'b0);
        applyStimulus(8'h6B, 1'b0, 1'b0, 11);
        checkOutput("after_reset_keycode", 32'(keyCode), 32'(last_code));

        // Pulse in flight when reset asserts must vanish immediately
        applyStimulus(8'h29, 1'b0, 1'b0, 10);
        @(negedge clk);
        kbd_dat = 1'b1;
        repeat (HALF) @(negedge clk);
        kbd_clk = 1'b0;
        stop_cycle = cycle_cnt;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (make) found = 1'b1;
        end
        checkOutput("inflight_seen", 32'(found), 32'h1);
        resetN = 1'b0;
        #1;
        checkOutput("inflight_cancel_make", 32'(make), 32'h0);
        checkOutput("inflight_cancel_keycode", 32'(keyCode), 32'h0);
        repeat (2) @(negedge clk);
        kbd_clk = 1'b1;
        resetN = 1'b1;
        last_code = 9'h000;
        repeat (3) @(negedge clk);
        expectKey(9'h01C, 1'b1, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0, 11);
        checkOutput("recover_keycode", 32'(keyCode), 32'(last_code));

        repeat (20) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/kbd_scan_decoder.md
KBD_SCAN_DECODER -- requirements
Module: kbd_scan_decoder

Interface
REQ-001 SHALL have parameter KEYCODE_WIDTH, default 9: output key code width, {extended flag, scan byte}.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: clk cycles without a keyboard clock falling edge before an open frame is aborted.
REQ-003 SHALL have port clk, input, 1: system clock; one clock domain.
REQ-004 SHALL have port resetN, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port kbd_clk, input, 1: raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port kbd_dat, input, 1: raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port keyCode, output, KEYCODE_WIDTH: last decoded key; bit 8 = E0 extended, bits 7:0 = scan byte.
REQ-008 SHALL have port make, output, 1: single-cycle pulse, key pressed.
REQ-009 SHALL have port brake, output, 1: single-cycle pulse, key released.

Function
REQ-010 SHALL synchronize kbd_clk and kbd_dat through two flip-flops each before use.
REQ-011 SHALL sample synchronized kbd_dat on every synchronized kbd_clk falling edge (high in previous cycle, low in current cycle).
REQ-012 Frame FSM SHALL use states IDLE, DATA, PARITY, STOP: IDLE->DATA on sampled 0 start bit; a sampled 1 in IDLE is ignored and the FSM stays in IDLE.
REQ-013 DATA SHALL shift 8 bits LSB first, then go to PARITY; PARITY samples one bit and goes to STOP; STOP samples one bit and always returns to IDLE.
REQ-014 A byte SHALL be accepted only if the stop bit is 1 (and parity rule per REQ-025); otherwise it is discarded silently.
REQ-015 Watchdog counter SHALL reset on every falling edge; if it reaches TIMEOUT_CYCLES outside IDLE, the FSM returns to IDLE, discards partial bits and clears the prefix flags.
REQ-016 Prefix handling: byte 0xE0 sets ext flag; 0xF0 sets brk flag; 0xE1 is discarded with flags unchanged; no output is produced for these bytes.
REQ-017 Any other accepted byte b SHALL load keyCode = {ext, b}, pulse brake if brk else make, then clear ext and brk.
REQ-018 make/brake SHALL be high for exactly one clk cycle, never both high, and SHALL assert 2 clk cycles after the cycle in which the stop-bit falling edge is detected.
REQ-019 keyCode SHALL hold its value between events and change only in the cycle its make/brake pulse asserts.
REQ-020 Back-to-back frames with no idle gap SHALL all be decoded; the FSM re-arms in IDLE one cycle after STOP.

Reset
REQ-021 resetN low SHALL asynchronously force keyCode=0, make=0, brake=0, FSM=IDLE, ext=brk=0, watchdog=0, synchronizers=1 (bus idle).
REQ-022 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after release SHALL decode correctly.
REQ-023 A pulse in flight when reset asserts SHALL be cancelled within that cycle.

Configuration
REQ-024 Macro KBD_PARITY_CHECK_EN SHALL select odd-parity checking.
REQ-025 Defined: a byte whose 8 data bits plus parity bit have even total ones SHALL be discarded and SHALL also clear ext and brk. Undefined: the parity bit is sampled and ignored.

Structure
REQ-026 Shared package kbd_pkg SHALL hold KEYCODE_WIDTH, the constants 0xE0/0xF0/0xE1, and the frame-state enum typedef.
REQ-027 Sub-module ps2_frame_rx SHALL contain the synchronizers, edge detection, frame FSM, watchdog and parity check, and emit byte/byte_valid; the top level SHALL hold the prefix FSM and output registers.

Verification
REQ-028 Frame 0x1C, valid parity -> keyCode=0x01C, make high 1 cycle, brake low.
REQ-029 Bytes E0,F0,4A -> keyCode=0x14A, single brake pulse, no make; a following 0x4A -> keyCode=0x04A, make pulse (flags cleared).
REQ-030 Bytes F0,75 -> keyCode=0x075, brake; 0x6C back-to-back with no gap -> keyCode=0x06C, make.
REQ-031 With KBD_PARITY_CHECK_EN defined, 0x1C with wrong parity -> no pulse and keyCode unchanged; with the macro undefined -> keyCode=0x01C, make.
REQ-032 Stop after 4 data bits for TIMEOUT_CYCLES+10 cycles, then send frame 0x5A -> no pulse during the stall, then keyCode=0x05A with make.
REQ-033 Send E0, assert resetN low mid-way through the next frame, release, send 0x6B -> keyCode=0x06B (ext cleared), make.
